// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a two-phase (toggle) request/acknowledge
// clock-domain crossing. A word accepted on the valid/ready interface is
// held on o_data while o_req toggles. The block then waits for the matching
// i_ack toggle, which is brought into i_clk through two flops.
module cdc_hs_tx #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] DEFAULT = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_req,
   input  logic             i_ack,
   output logic             o_done
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_ack_s1;
   logic             r_ack_s;
   logic             r_req;
   logic [WIDTH-1:0] r_data;
   logic             r_done;
   logic             w_done_next;
   logic             w_match;
   logic             w_accept;

   // The synchronized ack equals our request once the destination has
   // caught up. A mismatch in IDLE (spurious ack) keeps the block blocked.
   assign w_match  = (r_ack_s == r_req);
   assign o_ready  = (r_state == IDLE) && w_match;
   assign w_accept = i_valid && o_ready;

   // Two-flop synchronizer for the asynchronous acknowledge toggle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ack_s1 <= 1'b0;
         r_ack_s  <= 1'b0;
      end else begin
         r_ack_s1 <= i_ack;
         r_ack_s  <= r_ack_s1;
      end
   end

   // State register and one-cycle done pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_done_next;
      end
   end

   // Next-state decode: accept moves to WAIT_ACK, matching ack returns to IDLE.
   always_comb begin
      w_state_next = r_state;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (w_match) begin
               w_state_next = IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Capture the word and toggle the request only on accept, so o_data and
   // o_req stay frozen for the whole outstanding transfer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data <= DEFAULT;
         r_req  <= 1'b0;
      end else if (w_accept) begin
         r_data <= i_data;
         r_req  <= ~r_req;
      end
   end

   assign o_data = r_data;
   assign o_req  = r_req;
   assign o_done = r_done;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Testbench for cdc_hs_tx: directed stimulus with a scoreboard queue of
// accepted words; a monitor process checks o_data at accept, while held,
// and at each o_done pulse.
module tb_cdc_hs_tx;

   localparam int          WIDTH = 32;
   localparam logic [31:0] DEF   = 32'h0000_0005;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] data_in;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data_out;
   logic             req;
   logic             ack;
   logic             done;

   // Destination model: manual ack, or loopback of o_req delayed 4 cycles.
   logic             loop_en;
   logic             man_ack;
   logic [3:0]       req_pipe;

   int               n_pass;
   int               n_total;
   int               done_cnt;
   logic [31:0]      sb_q[$];
   logic             exp_req;

   cdc_hs_tx #(.WIDTH(WIDTH), .DEFAULT(DEF)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data_in),
      .i_valid (valid),
      .o_ready (ready),
      .o_data  (data_out),
      .o_req   (req),
      .i_ack   (ack),
      .o_done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) req_pipe <= 4'b0;
      else        req_pipe <= {req_pipe[2:0], req};
   end

   assign ack = loop_en ? req_pipe[3] : man_ack;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
         $display("ok   %s: 0x%08h at %0t", name, act, $time);
      end
   endtask

   // Monitor / scoreboard
   logic holding;
   logic last_req;
   initial begin
      holding  = 1'b0;
      last_req = 1'b0;
   end
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         holding  = 1'b0;
         last_req = req;
      end else begin
         if (req !== last_req) begin
            last_req = req;
            if (sb_q.size() == 0) chk("unexpected_accept", 32'd1, 32'd0);
            else                  chk("accept_data", data_out, sb_q[0]);
            holding = 1'b1;
         end else if (holding && !done && sb_q.size() != 0) begin
            chk("stable_data", data_out, sb_q[0]);
         end
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else                  chk("done_data", data_out, sb_q.pop_front());
            holding = 1'b0;
         end
      end
   end

   // Present a word and keep valid high until it is accepted.
   task automatic send(input logic [31:0] w);
      int n;
      data_in = w;
      valid   = 1'b1;
      sb_q.push_back(w);
      n = 0;
      @(negedge clk);
      while (!ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!ready) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      exp_req = ~exp_req;
      chk("req_toggle", {31'd0, req}, {31'd0, exp_req});
      chk("ready_low_after_accept", {31'd0, ready}, 32'd0);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 60) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
   endtask

   task automatic cycles(input int k);
      for (int i = 0; i < k; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      done_cnt = 0;
      exp_req  = 1'b0;
      rst_n    = 1'b0;
      valid    = 1'b0;
      data_in  = '0;
      man_ack  = 1'b0;
      loop_en  = 1'b0;

      // Reset values
      cycles(3);
      chk("rst_data", data_out, DEF);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(3);
      chk("ready_after_rst", {31'd0, ready}, 32'd1);

      // Single transfer with manual ack
      send(32'hA5A5_0001);
      valid = 1'b0;
      chk("single_data", data_out, 32'hA5A5_0001);
      cycles(2);
      chk("ready_wait", {31'd0, ready}, 32'd0);
      @(negedge clk);
      man_ack = 1'b1;
      cycles(1);  // edge E
      chk("done_E", {31'd0, done}, 32'd0);
      cycles(1);  // edge E+1
      chk("done_E1", {31'd0, done}, 32'd0);
      cycles(1);  // edge E+2
      chk("done_E2", {31'd0, done}, 32'd1);
      chk("ready_E2", {31'd0, ready}, 32'd1);
      cycles(1);
      chk("done_pulse_end", {31'd0, done}, 32'd0);

      // Back-to-back with 4-cycle loopback, valid held between words
      cycles(6);
      loop_en = 1'b1;
      send(32'h0000_0001);
      send(32'h0000_0002);
      // Wiggle i_data while waiting; it must be ignored
      valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_in = 32'hDEAD_0000 + i;
         @(negedge clk);
      end
      wait_done(3);
      chk("b2b_done_count", done_cnt, 32'd3);

      // Reset mid-transfer
      cycles(2);
      send(32'h0000_0003);
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      cycles(2);
      chk("midrst_req", {31'd0, req}, 32'd0);
      chk("midrst_data", data_out, DEF);
      chk("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_req = 1'b0;
      cycles(12);
      chk("midrst_no_done", done_cnt, 32'd3);

      // Spurious ack in IDLE
      man_ack = 1'b0;
      loop_en = 1'b0;
      cycles(4);
      chk("spur_ready_before", {31'd0, ready}, 32'd1);
      @(negedge clk);
      man_ack = 1'b1;
      cycles(1);
      chk("spur_ready_e1", {31'd0, ready}, 32'd1);
      cycles(1);
      chk("spur_ready_e2", {31'd0, ready}, 32'd0);
      cycles(4);
      chk("spur_blocked", {31'd0, ready}, 32'd0);
      @(negedge clk);
      man_ack = 1'b0;
      cycles(1);
      chk("spur_clear_e1", {31'd0, ready}, 32'd0);
      cycles(1);
      chk("spur_clear_e2", {31'd0, ready}, 32'd1);
      cycles(2);
      chk("final_done_count", done_cnt, 32'd3);
      chk("final_queue_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
